// File: rtl/ex_wb_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : ex_wb_writeback
//  Purpose  : Execute stage plus EX/WB pipeline register of the 8-bit
//             pipelined core. Computes the result of the decoded ID/EX
//             operation, registers it, and drives the register-file write
//             port. When the instruction in EX/WB writes the register that
//             the current instruction reads, its result is forwarded into
//             operand A.
//  Ports    :
//    Clk               in   1       rising-edge clock
//    Reset             in   1       asynchronous, active-low reset
//    Stall             in   1       hold EX/WB contents this cycle
//    Flush             in   1       load a bubble (no write) this cycle
//    ID_EX_Opcode      in   2       00 NOP, 01 MOV, 10 ADDI, 11 LI
//    ID_EX_RS          in   ADDR_W  source register index
//    ID_EX_RD          in   ADDR_W  destination register index
//    ID_EX_Read_Data   in   DATA_W  register-file read value for RS
//    ID_EX_Imm         in   DATA_W  sign-extended immediate
//    EX_WB_RD          out  ADDR_W  write index to register file
//    EX_WB_Write_Data  out  DATA_W  write data to register file
//    EX_WB_Reg_Write   out  1       write enable to register file
//    Fwd_Active        out  1       forwarding selected this cycle (comb)
//    Retire_Count      out  CNT_W   count of writes loaded into EX/WB
//  Revision : 1.0  initial release
// ============================================================================
module ex_wb_writeback #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [1:0]        ID_EX_Opcode,
  input  logic [ADDR_W-1:0] ID_EX_RS,
  input  logic [ADDR_W-1:0] ID_EX_RD,
  input  logic [DATA_W-1:0] ID_EX_Read_Data,
  input  logic [DATA_W-1:0] ID_EX_Imm,
  output logic [ADDR_W-1:0] EX_WB_RD,
  output logic [DATA_W-1:0] EX_WB_Write_Data,
  output logic              EX_WB_Reg_Write,
  output logic              Fwd_Active,
  output logic [CNT_W-1:0]  Retire_Count
);

  localparam logic [1:0] c_OP_NOP  = 2'b00;
  localparam logic [1:0] c_OP_MOV  = 2'b01;
  localparam logic [1:0] c_OP_ADDI = 2'b10;
  localparam logic [1:0] c_OP_LI   = 2'b11;

  // EX/WB pipeline state
  logic [ADDR_W-1:0] rd_q,   rd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q,   we_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;

  // Execute-stage combinational signals
  logic              fwd_w;
  logic [DATA_W-1:0] opa_w;
  logic [DATA_W-1:0] result_w;
  logic              valid_w;

  // --------------------------------------------------------------------------
  // Operand A selection. Only a pending write (we_q) may forward, so a bubble
  // left in EX/WB with RD=0 never hijacks a read of register 0.
  // --------------------------------------------------------------------------
  always_comb begin
    fwd_w = we_q && (rd_q == ID_EX_RS);
    opa_w = fwd_w ? data_q : ID_EX_Read_Data;
  end

  // --------------------------------------------------------------------------
  // Result computation; ADDI wraps modulo 2^DATA_W (carry discarded).
  // --------------------------------------------------------------------------
  always_comb begin
    result_w = '0;
    unique case (ID_EX_Opcode)
      c_OP_MOV:  result_w = opa_w;
      c_OP_ADDI: result_w = opa_w + ID_EX_Imm;
      c_OP_LI:   result_w = ID_EX_Imm;
      c_OP_NOP:  result_w = '0;
      default:   result_w = '0;
    endcase
  end

  assign valid_w = (ID_EX_Opcode != c_OP_NOP);

  // --------------------------------------------------------------------------
  // Next-state for EX/WB. Flush has priority over Stall; a stalled entry
  // keeps asserting its write, which is harmless since it rewrites the same
  // value to the same register.
  // --------------------------------------------------------------------------
  always_comb begin
    rd_d   = rd_q;
    data_d = data_q;
    we_d   = we_q;
    cnt_d  = cnt_q;
    if (Flush) begin
      rd_d   = '0;
      data_d = '0;
      we_d   = 1'b0;
    end else if (!Stall) begin
      rd_d   = ID_EX_RD;
      data_d = result_w;
      we_d   = valid_w;
      // Counter wraps silently at 2^CNT_W.
      cnt_d  = cnt_q + CNT_W'(valid_w);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rd_q   <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      rd_q   <= rd_d;
      data_q <= data_d;
      we_q   <= we_d;
      cnt_q  <= cnt_d;
    end
  end

  assign EX_WB_RD         = rd_q;
  assign EX_WB_Write_Data = data_q;
  assign EX_WB_Reg_Write  = we_q;
  assign Fwd_Active       = fwd_w;
  assign Retire_Count     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_wb_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_wb_writeback
//  Purpose  : Directed self-checking bench for ex_wb_writeback.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_wb_writeback;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 16;

  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] MOV  = 2'b01;
  localparam logic [1:0] ADDI = 2'b10;
  localparam logic [1:0] LI   = 2'b11;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Stall;
  logic              Flush;
  logic [1:0]        ID_EX_Opcode;
  logic [ADDR_W-1:0] ID_EX_RS;
  logic [ADDR_W-1:0] ID_EX_RD;
  logic [DATA_W-1:0] ID_EX_Read_Data;
  logic [DATA_W-1:0] ID_EX_Imm;
  logic [ADDR_W-1:0] EX_WB_RD;
  logic [DATA_W-1:0] EX_WB_Write_Data;
  logic              EX_WB_Reg_Write;
  logic              Fwd_Active;
  logic [CNT_W-1:0]  Retire_Count;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  ex_wb_writeback #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Stall            (Stall),
    .Flush            (Flush),
    .ID_EX_Opcode     (ID_EX_Opcode),
    .ID_EX_RS         (ID_EX_RS),
    .ID_EX_RD         (ID_EX_RD),
    .ID_EX_Read_Data  (ID_EX_Read_Data),
    .ID_EX_Imm        (ID_EX_Imm),
    .EX_WB_RD         (EX_WB_RD),
    .EX_WB_Write_Data (EX_WB_Write_Data),
    .EX_WB_Reg_Write  (EX_WB_Reg_Write),
    .Fwd_Active       (Fwd_Active),
    .Retire_Count     (Retire_Count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] rs, input logic [2:0] rd,
                       input logic [7:0] rdata, input logic [7:0] imm);
    ID_EX_Opcode    = op;
    ID_EX_RS        = rs;
    ID_EX_RD        = rd;
    ID_EX_Read_Data = rdata;
    ID_EX_Imm       = imm;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [2:0] rd, input logic [7:0] data,
                           input logic we, input logic [15:0] cnt);
    check({tag, ".rd"},   32'(EX_WB_RD),         32'(rd));
    check({tag, ".data"}, 32'(EX_WB_Write_Data), 32'(data));
    check({tag, ".we"},   32'(EX_WB_Reg_Write),  32'(we));
    check({tag, ".cnt"},  32'(Retire_Count),     32'(cnt));
  endtask

  initial begin
    Reset = 1'b0;
    Stall = 1'b0;
    Flush = 1'b0;
    drive(NOP, 3'd0, 3'd0, 8'h00, 8'h00);

    // Reset state
    tick();
    tick();
    check_out("reset", 3'd0, 8'h00, 1'b0, 16'd0);
    check("reset.fwd", 32'(Fwd_Active), 32'd0);

    @(negedge Clk);
    Reset = 1'b1;

    // LI r3,5 then ADDI r4 = r3 + 0xFD through forwarding (wraps to 0x02)
    drive(LI, 3'd0, 3'd3, 8'h00, 8'h05);
    #1;
    check("li.fwd", 32'(Fwd_Active), 32'd0);
    tick();
    check_out("li", 3'd3, 8'h05, 1'b1, 16'd1);
    drive(ADDI, 3'd3, 3'd4, 8'h00, 8'hFD);
    #1;
    check("addi.fwd", 32'(Fwd_Active), 32'd1);
    tick();
    check_out("addi", 3'd4, 8'h02, 1'b1, 16'd2);

    // Set EX_WB_RD=5, then MOV r1 <- r2 must use the register-file value
    drive(LI, 3'd0, 3'd5, 8'h00, 8'h11);
    tick();
    check_out("li5", 3'd5, 8'h11, 1'b1, 16'd3);
    drive(MOV, 3'd2, 3'd1, 8'h7E, 8'h00);
    #1;
    check("mov.fwd", 32'(Fwd_Active), 32'd0);
    tick();
    check_out("mov", 3'd1, 8'h7E, 1'b1, 16'd4);

    // ADDI r6 = 0x10 + 0x20, then stall 3 cycles with different inputs
    drive(ADDI, 3'd0, 3'd6, 8'h10, 8'h20);
    tick();
    check_out("addi6", 3'd6, 8'h30, 1'b1, 16'd5);
    Stall = 1'b1;
    drive(LI, 3'd0, 3'd7, 8'h00, 8'hAA);
    tick();
    check_out("stall1", 3'd6, 8'h30, 1'b1, 16'd5);
    drive(MOV, 3'd1, 3'd2, 8'h55, 8'h00);
    tick();
    check_out("stall2", 3'd6, 8'h30, 1'b1, 16'd5);
    drive(ADDI, 3'd4, 3'd3, 8'h01, 8'h01);
    tick();
    check_out("stall3", 3'd6, 8'h30, 1'b1, 16'd5);

    // Flush and Stall together: bubble loaded, counter unchanged
    Flush = 1'b1;
    drive(LI, 3'd0, 3'd7, 8'h00, 8'hAA);
    tick();
    check_out("flush", 3'd0, 8'h00, 1'b0, 16'd5);
    Flush = 1'b0;
    Stall = 1'b0;

    // Reset asserted mid-cycle with a live write in EX/WB
    drive(LI, 3'd0, 3'd2, 8'h00, 8'h44);
    tick();
    check_out("pre_rst", 3'd2, 8'h44, 1'b1, 16'd6);
    #2;
    Reset = 1'b0;
    #1;
    check_out("async_rst", 3'd0, 8'h00, 1'b0, 16'd0);
    tick();
    check_out("rst_hold", 3'd0, 8'h00, 1'b0, 16'd0);
    drive(NOP, 3'd0, 3'd0, 8'h00, 8'h00);
    @(negedge Clk);
    Reset = 1'b1;
    tick();
    check_out("post_rst", 3'd0, 8'h00, 1'b0, 16'd0);

    // Count up to 0xFFFF, then wrap with one LI; NOP leaves it alone
    drive(LI, 3'd0, 3'd0, 8'h00, 8'h01);
    for (int i = 0; i < 65535; i++) begin
      @(posedge Clk);
    end
    #1;
    check("cnt_max", 32'(Retire_Count), 32'h0000FFFF);
    tick();
    check("cnt_wrap", 32'(Retire_Count), 32'h00000000);
    drive(NOP, 3'd0, 3'd0, 8'h00, 8'h00);
    tick();
    check_out("nop", 3'd0, 8'h00, 1'b0, 16'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
